mem_wait_model: RTL and testbench
=================================

Name: mem_wait_model

Overview:
- Main-memory stage directly downstream of the cache controller FSM.
- Consumes MStrobe/MRW/LdCtr from the controller and performs a word read or write into a backing array after a programmable wait-state count.
- Reports completion on CtrSig, which the controller uses to leave its ReadMem/WriteMem states.
- Returns read data for the cache line fill.

Parameters:
- ADDR_W, 16, word-address width of MAddr.
- DATA_W, 32, data word width.
- MEM_DEPTH, 1024, words in the backing array; power of two, at most 2**ADDR_W.
- WAIT_CYCLES, 4, wait states per access; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- MStrobe  in  1  access request from controller.
- MRW  in  1  1 = read, 0 = write; sampled with MStrobe.
- LdCtr  in  1  reload the wait counter to WAIT_CYCLES-1.
- MAddr  in  ADDR_W  word address; sampled with MStrobe.
- MWData  in  DATA_W  write data; sampled with MStrobe.
- MRData  out  DATA_W  read data; registered, held until the next read completes.
- CtrSig  out  1  one-cycle completion pulse.
- MBusy  out  1  high while an access is pending, i.e. in WAIT or DONE.
- MErr  out  1  out-of-range flag; see Optional Feature.

Behaviour:
- Reset, asynchronous: state=IDLE, counter=0, latched addr/data/rw=0, MRData=0, CtrSig=0, MBusy=0, MErr=0.
- Array contents are not reset.
- FSM states are IDLE, WAIT, DONE.
- IDLE, on MStrobe=1:
  - latch MAddr, MWData, MRW;
  - counter <= WAIT_CYCLES-1;
  - go to WAIT.
- IDLE, on MStrobe=0: stay in IDLE.
- WAIT:
  - If LdCtr=1: counter <= WAIT_CYCLES-1 and stay in WAIT (restart). LdCtr has priority over decrement.
  - Else if counter != 0: counter decrements.
  - Else (counter == 0): perform the access at that edge. A write updates array[index]; a read loads MRData from array[index]. Go to DONE.
- DONE:
  - CtrSig=1 and MBusy=1 for exactly this cycle.
  - Go to IDLE unconditionally.
  - MStrobe in DONE is ignored; the controller must re-strobe from IDLE.
- Latency: MStrobe seen in cycle t gives CtrSig high in cycle t+WAIT_CYCLES+1 (t+5 at the default).
- MBusy = (state != IDLE), registered.
- MStrobe in WAIT is ignored; the latched request is unaffected.
- MAddr/MWData/MRW changes after the strobe cycle have no effect.
- index = latched addr[$clog2(MEM_DEPTH)-1:0].
- MRData changes only on read completion; a write completion leaves it unchanged.
- Reset asserted mid-WAIT aborts the access: no array write occurs and CtrSig does not pulse.
- LdCtr in IDLE or DONE has no effect.
- The counter is 8 bits wide and never underflows.

Optional Feature:
- Macro: MEM_OOR_CHECK_EN.
- Defined:
  - latched addr >= MEM_DEPTH raises MErr=1 in the DONE cycle alongside CtrSig;
  - the write is suppressed;
  - a read loads MRData=0.
- Undefined:
  - upper address bits are ignored, so the address wraps modulo MEM_DEPTH;
  - MErr is tied to 0;
  - the port stays present in both builds.

Decomposition:
- Package mem_pkg holds:
  - the mem_state_t enum {IDLE, WAIT, DONE};
  - constants MRW_READ=1'b1 and MRW_WRITE=1'b0;
  - default width constants.
- One sub-module, wait_counter: 8-bit loadable down-counter with ld, dec, load value, and a zero flag. It is instantiated once.

Test Plan:
- Reset mid-WAIT: write 0x55 to addr 0x00A (array previously holds 0x11), assert reset two cycles after the strobe. Required: no CtrSig pulse and MBusy=0 immediately. A subsequent read of 0x00A returns 0x11.
- Write then read: write 0xDEADBEEF to addr 0x010 at t=0, so CtrSig=1 at t=5. Strobe a read of 0x010 at t=7; CtrSig=1 at t=12 and MRData=0xDEADBEEF. MBusy is high for t=1..5.
- LdCtr restart: read strobe at t=0, LdCtr pulsed at t=3. Required: CtrSig at t=8, not t=5.
- Back-to-back strobes: MStrobe held high continuously for a read of addr 0x001. Required: CtrSig at t=5, t=11 and t=17; the DONE cycle is ignored; no extra pulses.
- Input stability: change MAddr to 0x020 and MWData one cycle after a write strobe to 0x030. Required: only array[0x030] is updated.
- Out-of-range with MEM_OOR_CHECK_EN defined: write 0x1234 to addr 0x400 (DEPTH 1024). Required: MErr=1 with CtrSig, and array[0x000] unchanged. With the macro undefined, array[0x000]=0x1234 and MErr=0.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the main-memory wait-state model.
//   mem_state_t : access FSM states (IDLE, WAIT, DONE)
//   MRW_READ / MRW_WRITE : encoding of the MRW request direction
//   DEF_*       : default widths and sizes
//   CNT_W       : width of the wait-state counter
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic MRW_READ  = 1'b1;
  localparam logic MRW_WRITE = 1'b0;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MEM_DEPTH   = 1024;
  localparam int DEF_WAIT_CYCLES = 4;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// Loadable down-counter used to time memory wait states. Load wins over
// decrement, and a decrement at zero is ignored so the count never wraps.
// Ports:
//   clk        in  clock
//   reset      in  asynchronous active-high reset (count -> 0)
//   i_ld       in  load i_load_val
//   i_dec      in  decrement request (ignored when count is zero)
//   i_load_val in  value loaded on i_ld
//   o_zero     out count == 0
// -----------------------------------------------------------------------------
module wait_counter
  import mem_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_ld,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_wait_model.sv
// -----------------------------------------------------------------------------
// mem_wait_model
// Main-memory stage behind the cache controller. A strobe in IDLE latches the
// request, WAIT burns WAIT_CYCLES cycles (restartable with LdCtr), the array
// access happens on the last WAIT edge, and DONE pulses CtrSig for one cycle.
//
// Handshake: MStrobe is only accepted in IDLE; MAddr/MWData/MRW are sampled on
// that same edge and ignored afterwards. CtrSig is a one-cycle pulse in DONE;
// MBusy is high through WAIT and DONE. A new request needs a fresh strobe in
// IDLE (strobes during WAIT or DONE are dropped).
//
// Optional build macro: MEM_OOR_CHECK_EN
//   defined   : latched address >= MEM_DEPTH sets MErr in DONE, suppresses
//               the write and returns 0 for a read
//   undefined : address wraps modulo MEM_DEPTH, MErr stays 0
//
// Ports:
//   clk      in  clock
//   reset    in  asynchronous active-high reset
//   MStrobe  in  access request
//   MRW      in  1 = read, 0 = write
//   LdCtr    in  restart the wait counter while in WAIT
//   MAddr    in  word address
//   MWData   in  write data
//   MRData   out registered read data, held until the next read completes
//   CtrSig   out completion pulse
//   MBusy    out access pending (WAIT or DONE)
//   MErr     out out-of-range flag (DONE cycle only)
// -----------------------------------------------------------------------------
module mem_wait_model
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic              LdCtr,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MWData,
  output logic [DATA_W-1:0] MRData,
  output logic              CtrSig,
  output logic              MBusy,
  output logic              MErr
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rw;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ctr_sig;
  logic              r_busy;
  logic              r_err;

  // Backing store; intentionally not reset.
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  logic             w_ld;
  logic             w_dec;
  logic             w_zero;
  logic             w_access;
  logic             w_wr_en;
  logic             w_oor;
  logic [IDX_W-1:0] w_idx;

  assign w_idx = r_addr[IDX_W-1:0];

`ifdef MEM_OOR_CHECK_EN
  // Extra bit so the compare is valid even when MEM_DEPTH == 2**ADDR_W.
  assign w_oor = ({1'b0, r_addr} >= (ADDR_W + 1)'(MEM_DEPTH));
`else
  // Upper address bits deliberately dropped: the address wraps.
  logic w_unused_addr;
  assign w_unused_addr = ^r_addr;
  assign w_oor = 1'b0;
`endif

  // LdCtr has priority: it both reloads the counter and blocks the access.
  assign w_ld     = ((r_state == IDLE) && MStrobe) || ((r_state == WAIT) && LdCtr);
  assign w_dec    = (r_state == WAIT) && !LdCtr;
  assign w_access = (r_state == WAIT) && !LdCtr && w_zero;
  assign w_wr_en  = w_access && (r_rw == MRW_WRITE) && !w_oor;

  wait_counter #(
    .W(CNT_W)
  ) u_wait_counter (
    .clk       (clk),
    .reset     (reset),
    .i_ld      (w_ld),
    .i_dec     (w_dec),
    .i_load_val(LOAD_VAL),
    .o_zero    (w_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rw      <= 1'b0;
      r_rdata   <= '0;
      r_ctr_sig <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ctr_sig <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (MStrobe) begin
            r_addr  <= MAddr;
            r_wdata <= MWData;
            r_rw    <= MRW;
            r_state <= WAIT;
            r_busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (w_access) begin
            r_state   <= DONE;
            r_ctr_sig <= 1'b1;
            r_err     <= w_oor;
            if (r_rw == MRW_READ) begin
              r_rdata <= w_oor ? '0 : r_mem[w_idx];
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Array write port; reset forces IDLE so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  assign MRData = r_rdata;
  assign CtrSig = r_ctr_sig;
  assign MBusy  = r_busy;
  assign MErr   = r_err;

endmodule

// File: tb/tb_mem_wait_model.sv
// -----------------------------------------------------------------------------
// tb_mem_wait_model
// Directed scenarios plus randomized transactions for mem_wait_model. The
// reference model tracks memory contents in an associative array and predicts
// completion timing from the latency rule (strobe + WAIT_CYCLES + 1, restarted
// from the last LdCtr seen while waiting).
// -----------------------------------------------------------------------------
module tb_mem_wait_model;
  import mem_pkg::*;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 32;
  localparam int MEM_DEPTH   = 1024;
  localparam int WAIT_CYCLES = 4;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              MStrobe = 1'b0;
  logic              MRW = 1'b0;
  logic              LdCtr = 1'b0;
  logic [ADDR_W-1:0] MAddr = '0;
  logic [DATA_W-1:0] MWData = '0;
  logic [DATA_W-1:0] MRData;
  logic              CtrSig;
  logic              MBusy;
  logic              MErr;

  always #5 clk = ~clk;

  mem_wait_model #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_DEPTH  (MEM_DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .MStrobe(MStrobe),
    .MRW    (MRW),
    .LdCtr  (LdCtr),
    .MAddr  (MAddr),
    .MWData (MWData),
    .MRData (MRData),
    .CtrSig (CtrSig),
    .MBusy  (MBusy),
    .MErr   (MErr)
  );

  // ---------------- scoreboard / model ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] cur_rdata = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_oor(input logic [ADDR_W-1:0] a);
`ifdef MEM_OOR_CHECK_EN
    return int'(a) >= MEM_DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_idx(input logic [ADDR_W-1:0] a);
    return int'(a) % MEM_DEPTH;
  endfunction

  function automatic bit ref_known(input logic [ADDR_W-1:0] a);
    return ref_oor(a) || ref_mem.exists(ref_idx(a));
  endfunction

  // ---------------- driver tasks ----------------
  // Entered and left at a falling edge with the DUT in IDLE.
  task automatic do_access(input logic rw, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input int ld_at);
    int done_k;
    bit oor;
    logic [DATA_W-1:0] rd;
    oor    = ref_oor(addr);
    done_k = WAIT_CYCLES + 1;
    if (rw == MRW_READ) begin
      if (oor) rd = '0;
      else     rd = ref_mem[ref_idx(addr)];
      exp_q.push_back(rd);
    end
    MStrobe = 1'b1;
    MRW     = rw;
    MAddr   = addr;
    MWData  = wdata;
    LdCtr   = 1'b0;
    check_val("idle_busy", 64'(MBusy), 64'(0));
    for (int k = 1; k <= done_k + 1; k++) begin
      @(negedge clk);
      if (k == done_k) begin
        if (rw == MRW_WRITE && !oor) ref_mem[ref_idx(addr)] = wdata;
        if (rw == MRW_READ) begin
          check_val("exp_q_nonempty", 64'(exp_q.size() > 0), 64'(1));
          if (exp_q.size() > 0) cur_rdata = exp_q.pop_front();
        end
      end
      check_val("ctrsig", 64'(CtrSig), 64'(k == done_k));
      check_val("mbusy",  64'(MBusy),  64'(k <= done_k));
      check_val("merr",   64'(MErr),   64'((k == done_k) && oor));
      check_val("mrdata", 64'(MRData), 64'(cur_rdata));
      // Noise on the request lines after the strobe cycle must be ignored.
      MStrobe = (k <= done_k) ? 1'($urandom_range(0, 1)) : 1'b0;
      MAddr   = addr ^ 16'h0010;
      MWData  = ~wdata;
      MRW     = ~rw;
      LdCtr   = (k == ld_at);
      if ((k == ld_at) && (k < done_k)) done_k = k + WAIT_CYCLES + 1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("gap_busy",   64'(MBusy),  64'(0));
      check_val("gap_ctrsig", 64'(CtrSig), 64'(0));
      check_val("gap_mrdata", 64'(MRData), 64'(cur_rdata));
      MStrobe = 1'b0;
      LdCtr   = 1'($urandom_range(0, 1));
    end
    LdCtr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] pool [8];
    int period;
    pool = '{16'h000, 16'h001, 16'h00A, 16'h010, 16'h020, 16'h030, 16'h3FF, 16'h400};

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_ctrsig", 64'(CtrSig), 64'(0));
    check_val("rst_mbusy",  64'(MBusy),  64'(0));
    check_val("rst_merr",   64'(MErr),   64'(0));
    check_val("rst_mrdata", 64'(MRData), 64'(0));
    reset = 1'b0;

    // Reset during WAIT aborts the write
    do_access(MRW_WRITE, 16'h00A, 32'h11, 0);
    MStrobe = 1'b1; MRW = MRW_WRITE; MAddr = 16'h00A; MWData = 32'h55;
    @(negedge clk);
    MStrobe = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("midrst_mbusy",  64'(MBusy),  64'(0));
    check_val("midrst_ctrsig", 64'(CtrSig), 64'(0));
    check_val("midrst_mrdata", 64'(MRData), 64'(0));
    cur_rdata = '0;
    @(negedge clk);
    reset = 1'b0;
    idle_cycles(8);
    do_access(MRW_READ, 16'h00A, '0, 0);

    // Write then read, then LdCtr restart on a read
    do_access(MRW_WRITE, 16'h010, 32'hDEADBEEF, 0);
    idle_cycles(1);
    do_access(MRW_READ, 16'h010, '0, 0);
    do_access(MRW_READ, 16'h010, '0, 3);

    // Back-to-back: strobe held high for a read of 0x001
    do_access(MRW_WRITE, 16'h001, 32'hA5A5_0001, 0);
    period  = WAIT_CYCLES + 2;
    MStrobe = 1'b1; MRW = MRW_READ; MAddr = 16'h001; LdCtr = 1'b0;
    for (int k = 1; k <= 3 * period; k++) begin
      @(negedge clk);
      if ((k % period) == period - 1) cur_rdata = ref_mem[1];
      check_val("b2b_ctrsig", 64'(CtrSig), 64'((k % period) == period - 1));
      check_val("b2b_mbusy",  64'(MBusy),  64'((k % period) != 0));
      check_val("b2b_mrdata", 64'(MRData), 64'(cur_rdata));
      if (k == 3 * period) MStrobe = 1'b0;
    end
    idle_cycles(2);

    // Input stability: address noise after a write to 0x030 points at 0x020
    do_access(MRW_WRITE, 16'h020, 32'h2020_2020, 0);
    do_access(MRW_WRITE, 16'h030, 32'h3030_3030, 0);
    do_access(MRW_READ,  16'h020, '0, 0);
    do_access(MRW_READ,  16'h030, '0, 0);

    // Out-of-range address
    do_access(MRW_WRITE, 16'h000, 32'h0000_AAAA, 0);
    do_access(MRW_WRITE, 16'h400, 32'h0000_1234, 0);
    do_access(MRW_READ,  16'h000, '0, 0);
    do_access(MRW_READ,  16'h400, '0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [ADDR_W-1:0] a;
      logic rw;
      int ld;
      if ($urandom_range(0, 3) == 0) a = ADDR_W'($urandom_range(0, 16'hFFFF));
      else a = pool[$urandom_range(0, 7)];
      rw = 1'($urandom_range(0, 1));
      if (rw == MRW_READ && !ref_known(a)) rw = MRW_WRITE;
      ld = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, WAIT_CYCLES + 2)) : 0;
      do_access(rw, a, $urandom, ld);
      idle_cycles(int'($urandom_range(0, 2)));
    end

    check_val("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
